// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and span helper for the VGA framebuffer
// write and display-side address logic.
package vga_pkg;

  localparam int unsigned COLS_W = 7;
  localparam int unsigned ROWS_W = 6;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEF_FB_BASE = 16'hC000;
  localparam int unsigned       DEF_COLS    = 80;
  localparam int unsigned       DEF_ROWS    = 60;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FIN
  } fb_state_e;

  // Clip a requested span to the room left before the grid edge.
  function automatic logic [7:0] clip_span(input logic [7:0] req, input logic [7:0] room);
    return (req < room) ? req : room;
  endfunction

endpackage

// File: rtl/fb_raster_stepper.sv
// Row-major raster walker over a clipped rectangle: holds the column/row
// counters and the row base address, and presents current/next address.
module fb_raster_stepper
  import vga_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        span_w,
  input  logic [7:0]        span_h,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);

  logic [ADDR_W-1:0] row_base;
  logic [7:0]        col_off;
  logic [7:0]        row_idx;
  logic [7:0]        w_q;
  logic [7:0]        h_q;
  logic              row_end;

  always_comb begin
    row_end   = (col_off == w_q - 8'd1);
    last      = row_end && (row_idx == h_q - 8'd1);
    cur_addr  = row_base + ADDR_W'(col_off);
    next_addr = row_end ? (row_base + ROW_STRIDE) : (cur_addr + ADDR_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base <= '0;
      col_off  <= '0;
      row_idx  <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else if (load) begin
      row_base <= start_addr;
      col_off  <= '0;
      row_idx  <= '0;
      w_q      <= span_w;
      h_q      <= span_h;
    end else if (step) begin
      if (row_end) begin
        row_base <= row_base + ROW_STRIDE;
        col_off  <= '0;
        row_idx  <= row_idx + 8'd1;
      end else begin
        col_off  <= col_off + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_writer.sv
// Rectangle-fill writer for BRAM port a of the VGA cell grid.
// Define VGA_FB_VBLANK_ONLY_EN to restrict writes to blanking cycles.
module vga_fb_writer
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE = DEF_FB_BASE,
  parameter int unsigned       COLS    = DEF_COLS,
  parameter int unsigned       ROWS    = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [COLS_W-1:0] cmd_col,
  input  logic [ROWS_W-1:0] cmd_row,
  input  logic [COLS_W-1:0] cmd_w,
  input  logic [ROWS_W-1:0] cmd_h,
  input  logic [WORD_W-1:0] cmd_word,
  input  logic              vga_blank_n,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_we
);

  localparam logic [7:0] COLS8 = 8'(COLS);
  localparam logic [7:0] ROWS8 = 8'(ROWS);

  fb_state_e state, state_n;

  logic              accept;
  logic              empty;
  logic              issue_ok;
  logic              load;
  logic              step;
  logic              last;
  logic [7:0]        col8, row8, w8, h8;
  logic [7:0]        span_w, span_h;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] addr_n;
  logic [WORD_W-1:0] data_n;
  logic [WORD_W-1:0] word_q;
  logic              we_n, ready_n, busy_n, done_n;

`ifdef VGA_FB_VBLANK_ONLY_EN
  assign issue_ok = !vga_blank_n;
`else
  logic unused_blank;
  assign unused_blank = vga_blank_n;
  assign issue_ok     = 1'b1;
`endif

  always_comb begin
    accept = cmd_valid && cmd_ready;
    col8   = {1'b0, cmd_col};
    row8   = {2'b00, cmd_row};
    w8     = {1'b0, cmd_w};
    h8     = {2'b00, cmd_h};
    empty  = (w8 == 8'd0) || (h8 == 8'd0) || (col8 >= COLS8) || (row8 >= ROWS8);
    span_w = clip_span(w8, COLS8 - col8);
    span_h = clip_span(h8, ROWS8 - row8);
    // Multiply by a constant only: folds to shift-add of the row index.
    start_addr = FB_BASE + ADDR_W'(cmd_row) * ADDR_W'(COLS) + ADDR_W'(cmd_col);
  end

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        if (accept) begin
          if (empty) begin
            state_n = FIN;
          end else begin
            state_n = FILL;
            load    = 1'b1;
            we_n    = issue_ok;
            if (issue_ok) begin
              addr_n = start_addr;
              data_n = cmd_word;
            end
          end
        end
      end
      FILL: begin
        if (ram_we && last) begin
          state_n = FIN;
        end else begin
          // Advance only past a cell actually written; a stalled cell is retried.
          step = ram_we;
          we_n = issue_ok;
          if (issue_ok) begin
            addr_n = ram_we ? next_addr : cur_addr;
            data_n = word_q;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n != FILL);
    busy_n  = (state_n == FILL);
    done_n  = (state_n == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      word_q    <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_data  <= data_n;
      if (load) word_q <= cmd_word;
    end
  end

  fb_raster_stepper #(
    .COLS(COLS)
  ) u_stepper (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .start_addr(start_addr),
    .span_w    (span_w),
    .span_h    (span_h),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .last      (last)
  );

endmodule

// File: tb/tb_vga_fb_writer.sv
// Scoreboard bench for vga_fb_writer: reference rectangle model feeds an
// event queue, a negedge monitor checks writes, done pulses and busy.
module tb_vga_fb_writer;

  localparam int TB_BASE = 'hC000;
  localparam int TB_COLS = 80;
  localparam int TB_ROWS = 60;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_col;
  logic [5:0]  cmd_row;
  logic [6:0]  cmd_w;
  logic [5:0]  cmd_h;
  logic [15:0] cmd_word;
  logic        vga_blank_n;
  logic        busy;
  logic        done;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;

  vga_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_col    (cmd_col),
    .cmd_row    (cmd_row),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_word   (cmd_word),
    .vga_blank_n(vga_blank_n),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    logic [15:0] data;
    int          exp_cyc;
    bit          rel;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wcount   = 0;
  int          last_wr  = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic        blank_at_edge = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    blank_at_edge = vga_blank_n;
  end

  initial begin
    int ph;
    ph = 0;
    vga_blank_n = 1'b1;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 6;
      vga_blank_n = (ph < 4);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every DUT write/done must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      chk("rst_we", ram_we, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      last_addr = '0;
      last_data = '0;
    end else begin
      chk("busy", busy, (sb.size() > 0 && !sb[0].is_done));
      if (ram_we) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write (cycle %0d)", ram_addr, ram_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", ram_addr, e.addr);
          chk("wr_data", ram_data, e.data);
`ifdef VGA_FB_VBLANK_ONLY_EN
          chk("wr_in_blank", blank_at_edge, 0);
`else
          chk("wr_cycle", cyc, e.exp_cyc);
`endif
        end
        wcount++;
        last_wr   = cyc;
        last_addr = ram_addr;
        last_data = ram_data;
      end else begin
        chk("addr_hold", ram_addr, last_addr);
        chk("data_hold", ram_data, last_data);
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          if (e.rel) chk("done_after_last", cyc, last_wr + 1);
          else       chk("done_cycle", cyc, e.exp_cyc);
          chk("done_ready", cmd_ready, 1);
        end
      end
    end
  end

  task automatic model_push(input int col, input int row, input int w, input int h,
                            input logic [15:0] word, input int k);
    int we_c, he_c, n;
    ev_t e;
    we_c = (col >= TB_COLS) ? 0 : ((w < TB_COLS - col) ? w : TB_COLS - col);
    he_c = (row >= TB_ROWS) ? 0 : ((h < TB_ROWS - row) ? h : TB_ROWS - row);
    n = 0;
    for (int r = 0; r < he_c; r++) begin
      for (int c = 0; c < we_c; c++) begin
        e.is_done = 0;
        e.addr    = 16'(TB_BASE + (row + r) * TB_COLS + col + c);
        e.data    = word;
        e.exp_cyc = k + 1 + n;
        e.rel     = 0;
        sb.push_back(e);
        n++;
      end
    end
    e.is_done = 1;
    e.addr    = '0;
    e.data    = '0;
    e.exp_cyc = k + 1 + n;
`ifdef VGA_FB_VBLANK_ONLY_EN
    e.rel     = (n > 0);
`else
    e.rel     = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic issue(input int col, input int row, input int w, input int h, input logic [15:0] word);
    int k, guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_col   = 7'(col);
    cmd_row   = 6'(row);
    cmd_w     = 7'(w);
    cmd_h     = 6'(h);
    cmd_word  = word;
    guard = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        chk("ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    k = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_col   = 7'($urandom);
    cmd_row   = 6'($urandom);
    cmd_w     = 7'($urandom);
    cmd_h     = 6'($urandom);
    cmd_word  = 16'($urandom);
    model_push(col, row, w, h, word, k);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int col, row, w, h, w0, guard;
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_col   = 7'd3;
    cmd_row   = 6'd2;
    cmd_w     = 7'd4;
    cmd_h     = 6'd4;
    cmd_word  = 16'hBEEF;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Directed cases, issued back to back so empties land in FIN.
    issue(3, 2, 1, 1, 16'hF800);
    issue(10, 5, 3, 2, 16'h07E0);
    issue(78, 59, 5, 3, 16'h1234);
    issue(7, 7, 0, 3, 16'hAAAA);
    issue(80, 4, 4, 1, 16'h5555);
    issue(0, 0, 2, 1, 16'h0F0F);
    drain();

    for (int i = 0; i < 30; i++) begin
      col = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 127) : $urandom_range(0, 79);
      row = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      w   = ($urandom_range(0, 7) == 0) ? $urandom_range(70, 127) : $urandom_range(0, 12);
      h   = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      issue(col, row, w, h, 16'($urandom));
    end
    drain();

    // Abort a 10x10 fill after seven writes.
    w0 = wcount;
    issue(5, 5, 10, 10, 16'hC3C3);
    guard = 0;
    while ((wcount - w0) < 7 && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    rst = 1'b0;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("abort_count", wcount - w0, 7);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    issue(79, 0, 3, 2, 16'h8001);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_writer.md
Name: vga_fb_writer

Overview:
- Write side of the VGA character/tile framebuffer; the display pipeline reads this BRAM on port b, and this block writes it on port a.
- Accepts rectangle-fill commands from the CPU over a valid/ready handshake.
- Emits one 16-bit word write per clock into the cell grid, in row-major order, clipped to the grid.
- Sits between the CPU-side command register and BRAM port a (addr_a/data_a/we_a).

Parameters:
- FB_BASE, 16'hC000, BRAM word address of grid cell (0,0).
- COLS, 80, grid width in cells.
- ROWS, 60, grid height in cells.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_col  in  7  left cell column.
- cmd_row  in  6  top cell row.
- cmd_w  in  7  width in cells.
- cmd_h  in  6  height in cells.
- cmd_word  in  16  word written to every cell in the rectangle.
- vga_blank_n  in  1  from vga_control, same clk domain; used only with the optional feature.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when a command completes.
- ram_addr  out  16  to BRAM addr_a.
- ram_data  out  16  to BRAM data_a.
- ram_we  out  1  to BRAM we_a.

Behaviour:
- Reset values while rst=0: cmd_ready=0, busy=0, done=0, ram_we=0, ram_addr=0, ram_data=0, state=IDLE. cmd_ready=1 from the first clock edge after release.
- Reset asserted mid-fill aborts immediately: ram_we drops asynchronously and no further writes occur. The partial fill is not undone.
- All outputs are registered.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge N, latch the command; go to FILL, or to FIN if the command is empty.
  - FILL: busy=1, cmd_ready=0. Write one cell per cycle.
  - FIN: busy=0, done=1 for one cycle, cmd_ready=1. A new command may be accepted in FIN; it behaves as if accepted in IDLE.
- Empty command: cmd_w==0, cmd_h==0, cmd_col>=COLS or cmd_row>=ROWS. No writes; done is high in cycle N+1.
- Clipping: we = min(cmd_w, COLS-cmd_col); he = min(cmd_h, ROWS-cmd_row). Compute in 8-bit unsigned to avoid wrap.
- Write timing: first write has ram_we=1 in cycle N+1. Exactly we*he writes follow, order col-fastest then row. done is high in the cycle after the last write.
- Address: ram_addr = FB_BASE + r*COLS + c, 16-bit modulo.
  - Generated incrementally, no multiplier: row_base += COLS at each row end; col offset increments per write.
- ram_data = latched cmd_word for every write.
- cmd_valid and command inputs are ignored while busy. Changing inputs after acceptance has no effect.
- ram_we=0 in every cycle that is not an issued write. ram_addr and ram_data hold their last values when ram_we=0.

Optional Feature:
- Macro VGA_FB_VBLANK_ONLY_EN.
- Defined: in FILL, a write issues only in cycles where vga_blank_n==0 is sampled at the preceding edge. Otherwise ram_we=0 and the position holds (stall). Latency then depends on blanking; write count and order are unchanged.
- Undefined: vga_blank_n is ignored and writes are issued every FILL cycle.

Decomposition:
- Shared package vga_pkg holds:
  - COLS_W=7, ROWS_W=6, WORD_W=16, ADDR_W=16.
  - Default FB_BASE, COLS, ROWS.
  - FSM state encoding {IDLE, FILL, FIN}.
- The display-side address generator uses the same package constants.
- One sub-module is natural: fb_raster_stepper.
  - Holds the col/row counters and row_base accumulator.
  - Outputs the next address and a last flag.
  - Inputs: load and step.
- The top module holds the FSM, handshake and output registers.

Test Plan:
- Reset: hold rst=0 with cmd_valid=1 → ram_we=0, cmd_ready=0, busy=0. Release → cmd_ready=1 next edge, no write without a handshake.
- 1x1 at col=3, row=2, word=16'hF800 → single write to addr 16'hC0A3, data F800, in cycle N+1; done in N+2.
- 3x2 at col=10, row=5, word=16'h07E0 → six consecutive writes to C19A, C19B, C19C, C1EA, C1EB, C1EC; busy for 6 cycles; done once.
- Clip: col=78, w=5, row=59, h=3, word=16'h1234 → exactly two writes, D2BE and D2BF; done in the cycle after.
- Empty: w=0, then col=80 w=4 h=1 → zero writes each time, done in N+1. Back-to-back accept in the FIN cycle works.
- Abort and optional feature:
  - 10x10 fill, pull rst low after 7 writes → ram_we=0 immediately, exactly 7 writes total.
  - With VGA_FB_VBLANK_ONLY_EN defined and vga_blank_n toggling 4 high / 2 low → writes only in low-sampled cycles, same 100 addresses in order.
